// File: rtl/delay_timer_pkg.sv
// Shared types, mode constants and elaboration helpers for the multi-channel delay timer.
package delay_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Clocks per base tick; 0 flags an unusable frequency pair.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned tick_freq);
    if (tick_freq == 0) return 0;
    return clk_freq / tick_freq;
  endfunction

  // Prescaler width, never below one bit.
  function automatic int unsigned calc_pw(input int unsigned div);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Per-channel request/status bundle between sequencing FSMs and the delay timer.
interface delay_timer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) ();

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    tick;

  modport master (
    output start, stop, periodic, period,
    input  busy, done, tick
  );

  modport slave (
    input  start, stop, periodic, period,
    output busy, done, tick
  );

endinterface

// File: rtl/delay_timer_ch.sv
// One delay channel: IDLE/RUN FSM with a tick-driven down-counter and latched mode/period.
module delay_timer_ch
  import delay_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    load_val = (period == '0) ? CNT_W'(1) : period;
  end

  // Priority: stop, then (re)start, then expiry; a load swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    per_d   = per_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (start) begin
      state_d = ST_RUN;
      rem_d   = load_val;
      per_d   = load_val;
      mode_d  = periodic;
    end else if (state_q == ST_RUN && tick) begin
      if (rem_q > CNT_W'(1)) begin
        rem_d = rem_q - CNT_W'(1);
      end else begin
        done_d = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          rem_d = per_q;
        end
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      per_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/delay_timer.sv
// Multi-channel programmable delay generator: one global prescaler feeding NUM_CH channels.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_FREQ = 1_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  delay_timer_if.slave bus
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, TICK_FREQ);
  localparam int unsigned PW  = calc_pw(DIV);

  if (DIV < 1) begin : g_bad_div
    $error("delay_timer: CLK_FREQ/TICK_FREQ must be >= 1");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_nch
    $error("delay_timer: NUM_CH must be in 1..16");
  end

  localparam logic [PW-1:0] CNT_MAX = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered from the next count so it is 0 in reset even when DIV = 1.
  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + PW'(1);
    tick_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_timer_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .arst_n   (arst_n),
      .tick     (tick_q),
      .start    (bus.start[i]),
      .stop     (bus.stop[i]),
      .periodic (bus.periodic[i]),
      .period   (bus.period[i*CNT_W +: CNT_W]),
      .busy     (busy_w[i]),
      .done     (done_w[i])
    );
  end

  assign bus.busy = busy_w;
  assign bus.done = done_w;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer: a DIV=1 instance driven from a vector table and a DIV=4 instance for phase tests.
module tb_delay_timer;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  delay_timer_if #(.NUM_CH(4), .CNT_W(16)) if1 ();
  delay_timer_if #(.NUM_CH(4), .CNT_W(16)) if4 ();

  delay_timer #(.CLK_FREQ(1000), .TICK_FREQ(1000), .NUM_CH(4), .CNT_W(16)) dut1 (
    .clk(clk), .arst_n(arst_n), .bus(if1)
  );
  delay_timer #(.CLK_FREQ(4000), .TICK_FREQ(1000), .NUM_CH(4), .CNT_W(16)) dut4 (
    .clk(clk), .arst_n(arst_n), .bus(if4)
  );

  typedef struct {
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  periodic;
    logic [63:0] period;
    logic [3:0]  exp_busy;
    logic [3:0]  exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input int p0, input int p1, input int p2, input int p3);
    return {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] pm,
                              input logic [63:0] pr, input logic [3:0] eb, input logic [3:0] ed);
    vec_t v;
    v.start = st; v.stop = sp; v.periodic = pm; v.period = pr;
    v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step1(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] pm,
                       input logic [63:0] pr);
    if1.start = st; if1.stop = sp; if1.periodic = pm; if1.period = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] pm,
                       input logic [63:0] pr);
    if4.start = st; if4.stop = sp; if4.periodic = pm; if4.period = pr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;

    // Reset held 3 cycles with every start asserted.
    if1.start = '1; if1.stop = '0; if1.periodic = '0; if1.period = pk(3, 3, 3, 3);
    if4.start = '1; if4.stop = '0; if4.periodic = '0; if4.period = pk(3, 3, 3, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d_busy1", i), 64'(if1.busy), 64'h0);
      chk($sformatf("rst%0d_done1", i), 64'(if1.done), 64'h0);
      chk($sformatf("rst%0d_tick1", i), 64'(if1.tick), 64'h0);
      chk($sformatf("rst%0d_busy4", i), 64'(if4.busy), 64'h0);
      chk($sformatf("rst%0d_tick4", i), 64'(if4.tick), 64'h0);
    end

    // Release: DIV=1 ticks every cycle, DIV=4 ticks on the 3rd, 7th edge after release.
    arst_n = 1'b1;
    if4.start = '0;
    for (int k = 1; k <= 8; k++) begin
      step1('0, '0, '0, '0);
      chk($sformatf("post_rst%0d_tick1", k), 64'(if1.tick), 64'h1);
      chk($sformatf("post_rst%0d_tick4", k), 64'(if4.tick), 64'((k % 4) == 3));
      chk($sformatf("post_rst%0d_busy1", k), 64'(if1.busy), 64'h0);
      chk($sformatf("post_rst%0d_busy4", k), 64'(if4.busy), 64'h0);
    end

    // One-shot ch0 P=5; period changes while running are ignored.
    vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, pk(5, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(9, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    // Period 0 on ch3 behaves as 1.
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b1000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    // Stop and start together on running ch2.
    vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, pk(0, 0, 3, 0), 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 3, 0), 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0100, 4'b0000, pk(0, 0, 3, 0), 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    // Restart of ch1 exactly on its expiry cycle.
    vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, pk(0, 2, 0, 0), 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 2, 0, 0), 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, pk(0, 2, 0, 0), 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    // All channels at once, periods 1..4.
    vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, pk(1, 2, 3, 4), 4'b1111, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b1110, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b1100, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b1000, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b1000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    // Periodic ch0 P=2, then stopped.
    vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, pk(2, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(7, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000));

    foreach (vecs[i]) begin
      step1(vecs[i].start, vecs[i].stop, vecs[i].periodic, vecs[i].period);
      chk($sformatf("vec%0d_busy", i), 64'(if1.busy), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 64'(if1.done), 64'(vecs[i].exp_done));
    end

    // Retrigger ch2: P=10 at edge 0, P=4 at edge 6 -> single done at edge 10.
    step1(4'b0100, '0, '0, pk(0, 0, 10, 0));
    chk("retrig_busy0", 64'(if1.busy[2]), 64'h1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) step1(4'b0100, '0, '0, pk(0, 0, 4, 0));
      else        step1('0, '0, '0, '0);
      chk($sformatf("retrig%0d_done", k), 64'(if1.done[2]), 64'(k == 10));
      chk($sformatf("retrig%0d_busy", k), 64'(if1.busy[2]), 64'(k < 10));
    end

    // Periodic ch1 on DIV=4, P=3: first done within phase bounds, then every 12 cycles.
    step4(4'b0010, '0, 4'b0010, pk(0, 3, 0, 0));
    chk("per4_busy_start", 64'(if4.busy[1]), 64'h1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      step4('0, '0, '0, pk(0, 1, 0, 0));
      cyc++;
      seen = if4.done[1];
    end
    chk("per4_first_latency_ok", 64'(seen && cyc >= 9 && cyc <= 13), 64'h1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      step4('0, '0, '0, '0);
      cyc++;
      seen = if4.done[1];
    end
    chk("per4_interval", 64'(seen ? cyc : 0), 64'd12);
    chk("per4_busy_held", 64'(if4.busy[1]), 64'h1);
    for (int k = 1; k <= 4; k++) step4('0, '0, '0, '0);
    chk("per4_busy_prestop", 64'(if4.busy[1]), 64'h1);
    step4('0, 4'b0010, '0, '0);
    chk("per4_busy_stop", 64'(if4.busy[1]), 64'h0);
    chk("per4_done_stop", 64'(if4.done[1]), 64'h0);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step4('0, '0, '0, '0);
      if (if4.done[1] || if4.busy[1]) cyc++;
    end
    chk("per4_quiet_after_stop", 64'(cyc), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
